// File: rtl/fake_mario_sw_pkg.sv
// Register map and control-field constants shared by the switch controller.
package fake_mario_sw_pkg;

    typedef enum logic [2:0] {
        ADDR_DATA = 3'd0,
        ADDR_RAW  = 3'd1,
        ADDR_MASK = 3'd2,
        ADDR_EDGE = 3'd3,
        ADDR_DIV  = 3'd4,
        ADDR_CTRL = 3'd5
    } sw_addr_e;

    localparam int unsigned CTRL_EN      = 0;
    localparam int unsigned CTRL_RISE_EN = 1;
    localparam int unsigned CTRL_FALL_EN = 2;
    localparam int unsigned CTRL_W       = 3;

    localparam logic [CTRL_W-1:0] CTRL_RESET = 3'b111;

    localparam int unsigned DEFAULT_DIV = 50000;

endpackage

// File: rtl/fake_mario_sw_debounce_bit.sv
// One switch bit: two-flop synchroniser, tick-driven sample history and debounced state.
module fake_mario_sw_debounce_bit #(
    parameter int unsigned STABLE_N = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_raw,
    input  logic i_tick,
    input  logic i_en,
    output logic o_sync,
    output logic o_data,
    output logic o_rise,
    output logic o_fall
);

    logic                r_meta;
    logic                r_sync;
    logic [STABLE_N-1:0] r_hist;
    logic                r_data;

    logic w_all1;
    logic w_all0;

    assign w_all1 = &r_hist;
    assign w_all0 = ~|r_hist;

    // Change pulses are the next-state compare, so edge capture lands on the same edge as DATA.
    assign o_rise = i_en && w_all1 && !r_data;
    assign o_fall = i_en && w_all0 &&  r_data;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_hist <= '0;
            r_data <= 1'b0;
        end else begin
            r_meta <= i_raw;
            r_sync <= r_meta;
            if (i_tick) begin
                r_hist <= {r_hist[STABLE_N-2:0], r_sync};
            end
            if (o_rise || o_fall) begin
                r_data <= w_all1;
            end
        end
    end

    assign o_sync = r_sync;
    assign o_data = r_data;

endmodule

// File: rtl/fake_mario_sw_ctrl.sv
// Avalon-MM switch controller: debounced state, edge capture with W1C, and masked level IRQ.
module fake_mario_sw_ctrl #(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned DIV_W       = 20,
    parameter int unsigned DEFAULT_DIV = fake_mario_sw_pkg::DEFAULT_DIV,
    parameter int unsigned STABLE_N    = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_port,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic             irq
);

    import fake_mario_sw_pkg::*;

    logic [WIDTH-1:0]  r_mask;
    logic [WIDTH-1:0]  r_edge;
    logic [DIV_W-1:0]  r_div;
    logic [DIV_W-1:0]  r_presc;
    logic [CTRL_W-1:0] r_ctrl;
    logic [31:0]       r_readdata;
    logic              r_irq;

    logic              w_wr;
    logic              w_wr_div;
    logic              w_tick;
    logic [WIDTH-1:0]  w_sync;
    logic [WIDTH-1:0]  w_data;
    logic [WIDTH-1:0]  w_rise;
    logic [WIDTH-1:0]  w_fall;
    logic [WIDTH-1:0]  w_edge_set;
    logic [WIDTH-1:0]  w_edge_clr;
    logic [31:0]       w_rd_next;
    logic              w_unused;

    assign w_unused = ^writedata;

    assign w_wr     = chipselect && !write_n;
    assign w_wr_div = w_wr && (address == ADDR_DIV);
    assign w_tick   = r_ctrl[CTRL_EN] && (r_presc == r_div);

    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        fake_mario_sw_debounce_bit #(
            .STABLE_N(STABLE_N)
        ) u_bit (
            .clk     (clk),
            .reset_n (reset_n),
            .i_raw   (in_port[g]),
            .i_tick  (w_tick),
            .i_en    (r_ctrl[CTRL_EN]),
            .o_sync  (w_sync[g]),
            .o_data  (w_data[g]),
            .o_rise  (w_rise[g]),
            .o_fall  (w_fall[g])
        );
    end

    assign w_edge_set = (w_rise & {WIDTH{r_ctrl[CTRL_RISE_EN]}})
                      | (w_fall & {WIDTH{r_ctrl[CTRL_FALL_EN]}});
    assign w_edge_clr = (w_wr && (address == ADDR_EDGE)) ? writedata[WIDTH-1:0] : '0;

    // A DIV write restarts the tick period from zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_presc <= '0;
        end else if (w_wr_div) begin
            r_presc <= '0;
        end else if (r_ctrl[CTRL_EN]) begin
            r_presc <= w_tick ? '0 : r_presc + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mask <= '0;
            r_div  <= DIV_W'(DEFAULT_DIV);
            r_ctrl <= CTRL_RESET;
        end else if (w_wr) begin
            case (address)
                ADDR_MASK: r_mask <= writedata[WIDTH-1:0];
                ADDR_DIV:  r_div  <= writedata[DIV_W-1:0];
                ADDR_CTRL: r_ctrl <= writedata[CTRL_W-1:0];
                default:   ;
            endcase
        end
    end

    // Set is applied after clear, so a new edge survives a coincident W1C.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_edge <= '0;
            r_irq  <= 1'b0;
        end else begin
            r_edge <= (r_edge & ~w_edge_clr) | w_edge_set;
            r_irq  <= |(r_edge & r_mask);
        end
    end

    always_comb begin
        w_rd_next = '0;
        case (address)
            ADDR_DATA: w_rd_next[WIDTH-1:0]  = w_data;
            ADDR_RAW:  w_rd_next[WIDTH-1:0]  = w_sync;
            ADDR_MASK: w_rd_next[WIDTH-1:0]  = r_mask;
            ADDR_EDGE: w_rd_next[WIDTH-1:0]  = r_edge;
            ADDR_DIV:  w_rd_next[DIV_W-1:0]  = r_div;
            ADDR_CTRL: w_rd_next[CTRL_W-1:0] = r_ctrl;
            default:   ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_readdata <= '0;
        end else begin
            r_readdata <= w_rd_next;
        end
    end

    assign readdata = r_readdata;
    assign irq      = r_irq;

endmodule

// File: tb/tb_fake_mario_sw_ctrl.sv
// Directed bench for fake_mario_sw_ctrl with hand-computed register and timing expectations.
`timescale 1ns/1ps
module tb_fake_mario_sw_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] in_port;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    fake_mario_sw_ctrl #(
        .WIDTH       (16),
        .DIV_W       (20),
        .DEFAULT_DIV (50000),
        .STABLE_N    (4)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_port    (in_port),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq        (irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        @(posedge clk);
        #1;
        d          = readdata;
        chipselect = 1'b0;
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic [31:0] exp_rst [8];
        logic        bounce [4];
        logic        seen;
        int          w_div, d_edge, t0, t1, f, n;

        exp_rst = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd50000, 32'd7, 32'd0, 32'd0};
        bounce  = '{1'b0, 1'b1, 1'b1, 1'b0};

        reset_n = 1'b0; in_port = '0; address = '0;
        chipselect = 1'b0; write_n = 1'b1; writedata = '0;
        d_edge = 0;

        // Reset state and full register map
        idle(3);
        check("rst_readdata", readdata, 32'd0);
        check("rst_irq", {31'b0, irq}, 32'd0);
        reset_n = 1'b1;
        for (int a = 0; a < 8; a++) begin
            bus_read(3'(a), rd);
            check($sformatf("rst_reg%0d", a), rd, exp_rst[a]);
        end

        // Basic debounce with DIV=3: four ticks of 4 cycles, DATA 17 edges after the DIV write
        bus_write(3'd4, 32'd3);
        w_div = cyc;
        bus_read(3'd4, rd);
        check("s2_div", rd, 32'd3);
        in_port = 16'h0001;
        idle(2);
        bus_read(3'd1, rd);
        check("s2_raw", rd, 32'h0001);
        bus_read(3'd0, rd);
        check("s2_data_early", rd, 32'h0000);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            bus_read(3'd0, rd);
            if (rd[0]) begin
                seen   = 1'b1;
                d_edge = cyc - 1;
            end
        end
        check("s2_data_set", rd, 32'h0001);
        check("s2_latency", 32'(d_edge - w_div), 32'd17);
        bus_read(3'd3, rd);
        check("s2_edge", rd, 32'h0001);
        check("s2_irq_masked", {31'b0, irq}, 32'd0);

        // Mask enables irq one cycle after the MASK update; W1C drops it one cycle after the clear
        bus_write(3'd2, 32'd1);
        check("s3_irq_lag", {31'b0, irq}, 32'd0);
        idle(1);
        check("s3_irq_on", {31'b0, irq}, 32'd1);
        bus_write(3'd3, 32'd1);
        check("s3_irq_hold", {31'b0, irq}, 32'd1);
        idle(1);
        check("s3_irq_off", {31'b0, irq}, 32'd0);

        // Bounce 0,1,1,0 (one tick per value) never gives four equal samples
        for (int i = 0; i < 4; i++) begin
            in_port[0] = bounce[i];
            idle(4);
        end
        in_port[0] = 1'b1;
        idle(20);
        bus_read(3'd0, rd);
        check("s3_data_stable", rd, 32'h0001);
        bus_read(3'd3, rd);
        check("s3_no_capture", rd, 32'h0000);
        check("s3_irq_quiet", {31'b0, irq}, 32'd0);

        // W1C landing on the same edge as the fall capture: the edge wins
        t0 = cyc;
        in_port[0] = 1'b0;
        t1 = t0 + 3;
        while (((t1 - d_edge + 1) % 4) != 0) t1++;
        f = t1 + 13;
        while (cyc < f - 1) idle(1);
        bus_write(3'd3, 32'd1);
        check("s4_irq_pre", {31'b0, irq}, 32'd0);
        idle(1);
        check("s4_irq_set", {31'b0, irq}, 32'd1);
        bus_read(3'd3, rd);
        check("s4_edge_wins", rd, 32'h0001);
        bus_read(3'd0, rd);
        check("s4_data_fell", rd, 32'h0000);
        bus_write(3'd3, 32'd1);
        check("s4_irq_hold", {31'b0, irq}, 32'd1);
        idle(1);
        check("s4_irq_clear", {31'b0, irq}, 32'd0);
        bus_read(3'd3, rd);
        check("s4_edge_clear", rd, 32'h0000);

        // Rise on bit 5 captured, fall ignored with fall_en=0
        in_port = 16'h0020;
        idle(30);
        bus_read(3'd0, rd);
        check("s5_data_b5", rd, 32'h0020);
        bus_read(3'd3, rd);
        check("s5_edge_b5", rd, 32'h0020);
        check("s5_irq_unmasked_bit", {31'b0, irq}, 32'd0);
        bus_write(3'd3, 32'h0020);
        bus_write(3'd5, 32'd3);
        in_port = 16'h0000;
        idle(30);
        bus_read(3'd0, rd);
        check("s5_data_fall", rd, 32'h0000);
        bus_read(3'd3, rd);
        check("s5_no_fall_edge", rd, 32'h0000);

        // Disabled: DATA/EDGE frozen, synchroniser still live, history held
        bus_write(3'd5, 32'd0);
        in_port = 16'hFFFF;
        idle(30);
        bus_read(3'd0, rd);
        check("s5_frozen_data", rd, 32'h0000);
        bus_read(3'd1, rd);
        check("s5_raw_live", rd, 32'hFFFF);
        bus_read(3'd3, rd);
        check("s5_frozen_edge", rd, 32'h0000);
        bus_read(3'd5, rd);
        check("s5_ctrl", rd, 32'd0);
        bus_write(3'd5, 32'd7);
        idle(1);
        bus_read(3'd0, rd);
        check("s5_hist_held", rd, 32'h0000);
        idle(30);
        bus_read(3'd0, rd);
        check("s5_reenabled", rd, 32'hFFFF);
        bus_read(3'd3, rd);
        check("s5_edge_all", rd, 32'hFFFF);
        check("s5_irq", {31'b0, irq}, 32'd1);

        // Asynchronous reset mid-debounce
        in_port = 16'h0000;
        idle(6);
        #3;
        reset_n = 1'b0;
        #1;
        check("s6_async_readdata", readdata, 32'd0);
        check("s6_async_irq", {31'b0, irq}, 32'd0);
        in_port = 16'h0003;
        idle(2);
        reset_n = 1'b1;
        bus_read(3'd0, rd); check("s6_data", rd, 32'd0);
        bus_read(3'd2, rd); check("s6_mask", rd, 32'd0);
        bus_read(3'd3, rd); check("s6_edge", rd, 32'd0);
        bus_read(3'd4, rd); check("s6_div", rd, 32'd50000);
        bus_read(3'd5, rd); check("s6_ctrl", rd, 32'd7);

        // DIV=0 ticks every cycle: empty history fills in 4 edges, DATA visible on the 6th read
        bus_write(3'd4, 32'd0);
        n  = 0;
        rd = '0;
        while (n < 20 && rd[1:0] != 2'b11) begin
            bus_read(3'd0, rd);
            n++;
        end
        check("s6_div0_latency", 32'(n), 32'd6);
        check("s6_data_after", rd, 32'h0003);
        bus_read(3'd3, rd);
        check("s6_edge_after", rd, 32'h0003);
        check("s6_irq_after", {31'b0, irq}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
